// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR controller.
// Optional build macro used by the top: FIR_COEF_SHADOW_EN (shadow coefficient bank).
package fir_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_COEF_W = 14;
  localparam int unsigned DEF_TAPS   = 6;
  localparam int unsigned DEF_ACC_W  = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Ceiling log2, minimum result 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate: full-precision signed product, sign-extended into a
// wrapping accumulator. o_sum_c exposes the running sum including the current product.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_c,
  output logic signed [ACC_W-1:0]  o_sum_c
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = $signed(PROD_W'(i_x)) * $signed(PROD_W'(i_c));
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign o_sum_c    = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (reset || i_clear) r_acc <= '0;
    else if (i_en)        r_acc <= o_sum_c;
  end

endmodule

// File: rtl/fir_tdm_controller.sv
// Time-multiplexed FIR: one MAC walks all taps per accepted sample, then holds the result.
// Define FIR_COEF_SHADOW_EN to write coefficients into a shadow bank applied on commit.
module fir_tdm_controller
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      coef_ready,
  input  logic                      coef_commit
);

  localparam int unsigned ADDR_W = clog2(TAPS);

  fir_state_e r_state, w_state_nxt;

  logic signed [DATA_W-1:0] r_x    [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic [ADDR_W-1:0]        r_idx;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_out_data;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_clear;
  logic                     w_mac_en;
  logic                     w_coef_wr;
  logic signed [ACC_W-1:0]  w_sum;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_accept  = in_valid && r_in_ready;
  assign w_last    = (r_idx == ADDR_W'(TAPS - 1));
  assign w_coef_wr = coef_we && coef_ready && ({1'b0, coef_addr} < (ADDR_W + 1)'(TAPS));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_mac_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_clear     = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (w_last) w_state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Delay line, tap index and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < int'(TAPS); i++) r_x[i] <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_x[0] <= in_data;
        for (int i = 1; i < int'(TAPS); i++) r_x[i] <= r_x[i-1];
        r_idx <= '0;
      end else if (r_state == MAC && !w_last) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
      if (r_state == MAC && w_last) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef FIR_COEF_SHADOW_EN
  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic                     r_pending;

  assign coef_ready = 1'b1;

  // Writes land in the shadow bank; the active bank only changes between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        r_shadow[i] <= '0;
        r_coef[i]   <= '0;
      end
    end else begin
      if (w_coef_wr) r_shadow[coef_addr] <= coef_wdata;
      if (r_state == IDLE && r_pending) begin
        for (int i = 0; i < int'(TAPS); i++) r_coef[i] <= r_shadow[i];
      end
      if (coef_commit)            r_pending <= 1'b1;
      else if (r_state == IDLE)   r_pending <= 1'b0;
    end
  end
`else
  logic w_unused_commit;

  assign w_unused_commit = coef_commit;
  assign coef_ready      = r_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end
`endif

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_en    (w_mac_en),
    .i_x     (r_x[r_idx]),
    .i_c     (r_coef[r_idx]),
    .o_sum_c (w_sum)
  );

endmodule

// File: tb/tb_fir_tdm_controller.sv
// Scoreboard bench for fir_tdm_controller: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fir_tdm_controller;

`ifdef FIR_COEF_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [32:0] out_data;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [13:0] coef_wdata = '0;
  logic               coef_ready;
  logic               coef_commit = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic signed [32:0] exp_q [$];

  always #5 clk = ~clk;

  fir_tdm_controller dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_ready  (coef_ready),
    .coef_commit (coef_commit)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0d want no output", out_data);
      end else begin
        logic signed [32:0] e;
        e = exp_q.pop_front();
        check($sformatf("out_data[%0d]", n_out), out_data, e);
      end
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic signed [13:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    tick();
  endtask

  task automatic send(input logic signed [15:0] d, input bit push, input logic signed [32:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [32:0] t4_exp [6];
    int n;
    t4_exp[0] = 33'sd268410880;
    t4_exp[1] = 33'sd536846336;
    t4_exp[2] = 33'sd805281792;
    t4_exp[3] = 33'sd1073717248;
    t4_exp[4] = 33'sd1342160896;
    t4_exp[5] = 33'sd1610612736;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_coef_ready", coef_ready, 1);
    tick();

    // Test 1: impulse response with c=[1..6]; out-of-range addresses discarded
    for (int a = 0; a < 6; a++) wr_coef(3'(a), 14'(a + 1));
    wr_coef(3'd6, 14'sd77);
    wr_coef(3'd7, -14'sd5);
    commit();
    send(16'sd100, 1'b1, 33'sd100);
    for (int k = 1; k < 6; k++) send(16'sd0, 1'b1, 33'(100 * (k + 1)));
    drain();
    tick();

    // Test 2: latency and in_ready blocking, x=[1,0,..]
    send(16'sd1, 1'b1, 33'sd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("t2_in_ready_c%0d", k), in_ready, 0);
      check($sformatf("t2_out_valid_c%0d", k), out_valid, (k == 7) ? 1 : 0);
    end
    drain();
    tick();

    // Test 3: backpressure holds the result, x=[2,1,0,..] -> 2*1+1*2
    out_ready = 1'b0;
    send(16'sd2, 1'b1, 33'sd4);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t3_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t3_hold_valid_%0d", i), out_valid, 1);
      check($sformatf("t3_hold_data_%0d", i), out_data, 4);
      check($sformatf("t3_hold_in_ready_%0d", i), in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    drain();
    tick();

    // Test 4: full-scale negative samples and coefficients
    for (int a = 0; a < 6; a++) wr_coef(3'(a), -14'sd8192);
    commit();
    for (int k = 0; k < 6; k++) send(-16'sd32768, 1'b1, t4_exp[k]);
    drain();
    tick();

    // Test 5: coefficient write during MAC
    for (int a = 0; a < 6; a++) wr_coef(3'(a), (a == 0) ? 14'sd1 : 14'sd0);
    commit();
    send(16'sd3, 1'b1, 33'sd3);
    tick();
    coef_we     = 1'b1;
    coef_addr   = 3'd0;
    coef_wdata  = 14'sd9;
    coef_commit = 1'b1;
    @(negedge clk);
    check("t5_coef_ready_mac", coef_ready, SHADOW ? 1 : 0);
    tick();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    drain();
    tick();
    send(16'sd5, 1'b1, SHADOW ? 33'sd45 : 33'sd5);
    drain();
    tick();

    // Test 6: reset mid-MAC aborts the frame and clears state
    send(16'sd11, 1'b0, 33'sd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_data", out_data, 0);
    tick();
    wr_coef(3'd0, 14'sd1);
    commit();
    send(16'sd7, 1'b1, 33'sd7);
    drain();
    repeat (12) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
